// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the scan-phase encoding used by
// both scan axes of the VGA timing generator.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} scan_phase_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Scan interface between the timing generator and the sprite/palette
// renderers and DAC pins.
interface vga_timing_gen_if;

  logic        hs;
  logic        vs;
  logic        blank;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

  modport slave (
    input hs, vs, blank, DrawX, DrawY, line_start, frame_start, frame_count
  );

endinterface

// File: rtl/vga_timing_gen_scan_axis_counter.sv
// One scan axis: a wrapping position counter plus its ACTIVE/FP/SYNC/BP
// phase FSM, stepping only when 'advance' is high.
module scan_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE  = 640,
  parameter int FRONT    = 16,
  parameter int SYNC_LEN = 96,
  parameter int BACK     = 48,
  parameter int WIDTH    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output scan_phase_t      next_phase,
  output logic             wrap
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC_LEN + BACK;
  localparam logic [WIDTH-1:0] LAST_ACTIVE = WIDTH'(VISIBLE - 1);
  localparam logic [WIDTH-1:0] LAST_FP     = WIDTH'(VISIBLE + FRONT - 1);
  localparam logic [WIDTH-1:0] LAST_SYNC   = WIDTH'(VISIBLE + FRONT + SYNC_LEN - 1);
  localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);

  scan_phase_t      phase;
  logic [WIDTH-1:0] next_count;

  assign wrap = advance && (count == LAST);

  always_comb begin
    next_count = count;
    if (advance) begin
      next_count = (count == LAST) ? '0 : count + 1'b1;
    end
  end

  // Phase changes on the last count of each region, so it always matches next_count.
  always_comb begin
    next_phase = phase;
    if (advance) begin
      case (phase)
        ACTIVE: if (count == LAST_ACTIVE) next_phase = FP;
        FP:     if (count == LAST_FP)     next_phase = SYNC;
        SYNC:   if (count == LAST_SYNC)   next_phase = BP;
        BP:     if (count == LAST)        next_phase = ACTIVE;
        default:                          next_phase = ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      phase <= ACTIVE;
    end else begin
      count <= next_count;
      phase <= next_phase;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: counters, registered sync/blank decode,
// line/frame strobes and a completed-frame counter, all edge-aligned.
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  scan
);

  import vga_timing_pkg::*;

  logic [COORD_W-1:0] hc;
  logic [COORD_W-1:0] vc;
  scan_phase_t        h_next_phase;
  scan_phase_t        v_next_phase;
  logic               h_wrap;
  logic               v_wrap;
  logic               frame_wrap;

  logic        hs_q;
  logic        vs_q;
  logic        blank_q;
  logic        line_start_q;
  logic        frame_start_q;
  logic [15:0] frame_count;

  scan_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC_LEN(H_SYNC),
    .BACK    (H_BACK),
    .WIDTH   (COORD_W)
  ) h_axis (
    .clk       (vga_clk),
    .rst       (reset),
    .advance   (1'b1),
    .count     (hc),
    .next_phase(h_next_phase),
    .wrap      (h_wrap)
  );

  scan_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC_LEN(V_SYNC),
    .BACK    (V_BACK),
    .WIDTH   (COORD_W)
  ) v_axis (
    .clk       (vga_clk),
    .rst       (reset),
    .advance   (h_wrap),
    .count     (vc),
    .next_phase(v_next_phase),
    .wrap      (v_wrap)
  );

  assign frame_wrap = h_wrap && v_wrap;

  // Decoding the upcoming phases keeps every strobe in step with DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count   <= '0;
    end else begin
      hs_q          <= (h_next_phase != SYNC);
      vs_q          <= (v_next_phase != SYNC);
      blank_q       <= (h_next_phase == ACTIVE) && (v_next_phase == ACTIVE);
      line_start_q  <= h_wrap;
      frame_start_q <= frame_wrap;
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign scan.hs          = hs_q;
  assign scan.vs          = vs_q;
  assign scan.blank       = blank_q;
  assign scan.DrawX       = hc;
  assign scan.DrawY       = vc;
  assign scan.line_start  = line_start_q;
  assign scan.frame_start = frame_start_q;
  assign scan.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster so several full
// frames, random async resets and a frame_count rollover fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 40, HF = 4, HS = 8, HB = 6;
  localparam int VV = 30, VF = 3, VS = 2, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int F  = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  logic vga_clk;
  logic reset;

  vga_timing_gen_if scan ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .vga_clk(vga_clk),
    .reset  (reset),
    .scan   (scan)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  obs_t        exp_q[$];
  int unsigned k;
  logic [15:0] fc_model;
  int          checks;
  int          errors;

  int unsigned cyc;
  int          hs_run, vs_run, blank_cnt;
  bit          hs_run_valid, vs_run_valid, fs_valid;
  int unsigned last_fs;

  // Reference: k = edges since reset release; position is plain raster arithmetic.
  function automatic obs_t expected(input logic rst, input int unsigned kk, input logic [15:0] fc);
    obs_t        e;
    int unsigned x, y;
    if (rst || kk == 0) begin
      e = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, x: 10'd0, y: 10'd0, ls: 1'b0, fs: 1'b0, fc: 16'd0};
      return e;
    end
    x       = kk % HT;
    y       = (kk / HT) % VT;
    e.hs    = !(x >= HV + HF && x < HV + HF + HS);
    e.vs    = !(y >= VV + VF && y < VV + VF + VS);
    e.blank = (x < HV) && (y < VV);
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.ls    = (x == 0);
    e.fs    = (x == 0) && (y == 0);
    e.fc    = fc;
    return e;
  endfunction

  task automatic advance_model();
    if (reset) begin
      k        = 0;
      fc_model = 16'd0;
    end else begin
      k++;
      if (k % F == 0) fc_model++;
    end
  endtask

  task automatic apply_stimulus(input logic rst_next);
    @(posedge vga_clk);
    advance_model();
    #1;
    reset = rst_next;
    exp_q.push_back(expected(reset, k, fc_model));
  endtask

  task automatic run_cycles(input int n);
    repeat (n) apply_stimulus(1'b0);
  endtask

  task automatic run_until_pos(input int unsigned pos);
    for (int i = 0; i < F + 2 && (k % F) != pos; i++) apply_stimulus(1'b0);
  endtask

  task automatic reset_pulse(input int n);
    repeat (n) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
  endtask

  task automatic force_frame_count();
    @(posedge vga_clk);
    advance_model();
    #1;
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    fc_model = 16'hFFFF;
    exp_q.push_back(expected(reset, k, fc_model));
  endtask

  task automatic check_output();
    obs_t act, e;
    act = {scan.hs, scan.vs, scan.blank, scan.DrawX, scan.DrawY,
           scan.line_start, scan.frame_start, scan.frame_count};
    cyc++;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL cycle_outputs cyc=%0d actual hs=%b vs=%b blank=%b x=%0d y=%0d ls=%b fs=%b fc=%0d required hs=%b vs=%b blank=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
               cyc, act.hs, act.vs, act.blank, act.x, act.y, act.ls, act.fs, act.fc,
               e.hs, e.vs, e.blank, e.x, e.y, e.ls, e.fs, e.fc);
    end
    if (reset) begin
      hs_run = 0; vs_run = 0; blank_cnt = 0;
      hs_run_valid = 0; vs_run_valid = 0; fs_valid = 0;
      return;
    end
    if (!act.hs) hs_run++;
    else begin
      if (hs_run > 0 && hs_run_valid) begin
        checks++;
        if (hs_run != HS) begin
          errors++;
          $display("[TB] FAIL hs_width actual=%0d required=%0d", hs_run, HS);
        end
      end
      hs_run = 0; hs_run_valid = 1;
    end
    if (!act.vs) vs_run++;
    else begin
      if (vs_run > 0 && vs_run_valid) begin
        checks++;
        if (vs_run != VS * HT) begin
          errors++;
          $display("[TB] FAIL vs_width actual=%0d required=%0d", vs_run, VS * HT);
        end
      end
      vs_run = 0; vs_run_valid = 1;
    end
    if (act.fs) begin
      if (fs_valid) begin
        checks += 2;
        if (cyc - last_fs != F) begin
          errors++;
          $display("[TB] FAIL frame_period actual=%0d required=%0d", cyc - last_fs, F);
        end
        if (blank_cnt != HV * VV) begin
          errors++;
          $display("[TB] FAIL visible_count actual=%0d required=%0d", blank_cnt, HV * VV);
        end
      end
      last_fs = cyc; fs_valid = 1; blank_cnt = 0;
    end
    if (act.blank) blank_cnt++;
  endtask

  initial begin
    forever begin
      @(negedge vga_clk);
      check_output();
    end
  end

  initial begin
    int n;
    k = 0; fc_model = 16'd0; checks = 0; errors = 0; cyc = 0;
    hs_run = 0; vs_run = 0; blank_cnt = 0; last_fs = 0;
    hs_run_valid = 0; vs_run_valid = 0; fs_valid = 0;
    reset = 1'b1;
    repeat (4) apply_stimulus(1'b1);
    apply_stimulus(1'b0);
    $display("[TB] reset released, scanning two and a half frames");
    run_cycles(2 * F + F / 2);

    run_until_pos(F - 5);
    force_frame_count();
    run_cycles(20);

    for (int i = 0; i < 6; i++) begin
      run_cycles($urandom_range(3000, 50));
      n = $urandom_range(4, 1);
      reset_pulse(n);
    end

    run_until_pos(20 * HT + 30 - 1);
    reset_pulse(3);
    run_cycles(F + 100);

    @(negedge vga_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
